inst_mem_loader: RTL and testbench

- Instruction-store stage directly upstream of the 8-bit processor.
- Accepts a program image over a valid/ready byte stream and writes it into an internal DEPTH x 8 instruction memory.
- Holds the processor in clear while loading, then releases it and serves INST = mem[PC] for the processor's IR.
- Also reports program length and an XOR checksum of the loaded image.

---
 rtl/inst_mem_loader.sv | 159 +++++++++++++++
 tb/tb_inst_mem_loader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// Instruction store ahead of the 8-bit CPU: loads a byte-stream image, then
// releases the CPU and serves INST = mem[PC].
//
// Ports:
//   clk, CLB            clock and synchronous active-high reset
//   load_start          pulse that begins or restarts a program load
//   wr_valid/wr_data/   byte stream in; wr_last marks the final byte,
//   wr_last/wr_ready    wr_ready is high only while loading
//   PC / INST           processor fetch address / instruction byte
//   cpu_CLB             active-low clear to the processor
//   busy                high while loading or holding the CPU in clear
//   prog_len, checksum  length and XOR of the last or current image
//   full                image filled DEPTH bytes without wr_last
module inst_mem_loader #(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              CLB,
    input  logic              load_start,
    input  logic              wr_valid,
    input  logic [7:0]        wr_data,
    input  logic              wr_last,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] PC,
    output logic [7:0]        INST,
    output logic              cpu_CLB,
    output logic              busy,
    output logic [ADDR_W:0]   prog_len,
    output logic [7:0]        checksum,
    output logic              full
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN
    } state_e;

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(HOLD_CYCLES - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [7:0]        cks_q, cks_d;
    logic              full_q, full_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_ready_q, busy_q, cpu_clb_q;
    logic              we;

    logic [7:0] mem_q [DEPTH];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cks_d   = cks_q;
        full_d  = full_q;
        cnt_d   = cnt_q;
        we      = 1'b0;
        // A restart wins in every state, including over a byte offered in
        // the same cycle: that byte is dropped.
        if (load_start) begin
            state_d = S_LOAD;
            addr_d  = '0;
            len_d   = '0;
            cks_d   = '0;
            full_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: ;
                S_LOAD: begin
                    if (wr_valid) begin
                        we     = 1'b1;
                        addr_d = addr_q + ADDR_ONE;
                        len_d  = len_q + LEN_ONE;
                        cks_d  = cks_q ^ wr_data;
                        if (wr_last) begin
                            state_d = S_HOLD;
                            cnt_d   = '0;
                        end else if (addr_q == ADDR_LAST) begin
                            state_d = S_HOLD;
                            full_d  = 1'b1;
                            cnt_d   = '0;
                        end
                    end
                end
                S_HOLD: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_RUN: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output flags are registered from the next state so they line up
    // exactly with state_q after each edge.
    always_ff @(posedge clk) begin
        if (CLB) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            cks_q      <= '0;
            full_q     <= 1'b0;
            cnt_q      <= '0;
            wr_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            cpu_clb_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            cks_q      <= cks_d;
            full_q     <= full_d;
            cnt_q      <= cnt_d;
            wr_ready_q <= (state_d == S_LOAD);
            busy_q     <= (state_d == S_LOAD) || (state_d == S_HOLD);
            cpu_clb_q  <= (state_d == S_RUN);
        end
    end

    // Image storage is never cleared; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!CLB && we) begin
            mem_q[addr_q] <= wr_data;
        end
    end

    // Fetch is combinational and only exposes bytes of the current image.
    always_comb begin
        INST = 8'h00;
        if (state_q == S_RUN && {1'b0, PC} < len_q) begin
            INST = mem_q[PC];
        end
    end

    assign wr_ready = wr_ready_q;
    assign busy     = busy_q;
    assign cpu_CLB  = cpu_clb_q;
    assign prog_len = len_q;
    assign checksum = cks_q;
    assign full     = full_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: stimulus pushes expectations,
// a negedge monitor pops and compares them.
module tb_inst_mem_loader;

    localparam int HOLD = 2;

    logic       clk = 1'b0;
    logic       CLB = 1'b1;
    logic       load_start = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_last = 1'b0;
    logic       wr_ready;
    logic [7:0] PC = 8'h00;
    logic [7:0] INST;
    logic       cpu_CLB;
    logic       busy;
    logic [8:0] prog_len;
    logic [7:0] checksum;
    logic       full;

    inst_mem_loader #(
        .DEPTH(256),
        .ADDR_W(8),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk),
        .CLB(CLB),
        .load_start(load_start),
        .wr_valid(wr_valid),
        .wr_data(wr_data),
        .wr_last(wr_last),
        .wr_ready(wr_ready),
        .PC(PC),
        .INST(INST),
        .cpu_CLB(cpu_CLB),
        .busy(busy),
        .prog_len(prog_len),
        .checksum(checksum),
        .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         len;
        logic [7:0] cks;
        logic       full;
    } load_exp_t;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] exp_acc[$];
    load_exp_t  exp_load[$];
    logic [7:0] exp_inst[$];
    logic       fetch_req = 1'b0;

    // Behavioural model: image bytes as a queue, memory as an array.
    logic [7:0] model_mem[256];
    logic [7:0] img_q[$];
    bit         last_seen = 0;
    bit         model_run = 0;
    int         model_len = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares whatever the DUT presents against queued values.
    initial begin : monitor
        int  cyc;
        int  last_acc;
        bit  prev_clb;
        cyc = 0;
        last_acc = 0;
        prev_clb = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!CLB && wr_valid && wr_ready && !load_start) begin
                if (exp_acc.size() == 0) begin
                    chk("unexpected_accept", {24'h0, wr_data}, 32'hFFFF_FFFF);
                end else begin
                    chk("accept_data", {24'h0, wr_data},
                        {24'h0, exp_acc.pop_front()});
                end
                last_acc = cyc;
            end
            if (cpu_CLB && !prev_clb) begin
                if (exp_load.size() == 0) begin
                    chk("unexpected_release", 32'(cpu_CLB), 32'h0);
                end else begin
                    load_exp_t e;
                    e = exp_load.pop_front();
                    chk("prog_len", 32'(prog_len), 32'(e.len));
                    chk("checksum", 32'(checksum), 32'(e.cks));
                    chk("full", 32'(full), 32'(e.full));
                    chk("hold_cycles", 32'(cyc - last_acc), 32'(HOLD + 1));
                    chk("busy_run", 32'(busy), 32'h0);
                end
            end
            prev_clb = cpu_CLB;
            if (fetch_req) begin
                if (exp_inst.size() == 0) begin
                    chk("fetch_queue", 32'h0, 32'h1);
                end else begin
                    chk("inst", 32'(INST), 32'(exp_inst.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        img_q.delete();
        last_seen = 0;
        model_run = 0;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        wr_valid = 1'b1;
        wr_data = b;
        wr_last = last;
        model_mem[img_q.size() % 256] = b;
        img_q.push_back(b);
        if (last) last_seen = 1;
        exp_acc.push_back(b);
        tick();
        wr_valid = 1'b0;
        wr_last = 1'b0;
    endtask

    task automatic restart_with_byte(input logic [7:0] b);
        load_start = 1'b1;
        wr_valid = 1'b1;
        wr_data = b;
        tick();
        load_start = 1'b0;
        wr_valid = 1'b0;
        img_q.delete();
        last_seen = 0;
    endtask

    task automatic expect_done();
        load_exp_t e;
        bit        seen;
        e.len = img_q.size();
        e.cks = 8'h00;
        foreach (img_q[i]) e.cks ^= img_q[i];
        e.full = (img_q.size() == 256) && !last_seen;
        exp_load.push_back(e);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (cpu_CLB) seen = 1;
        end
        chk("release_seen", 32'(seen), 32'h1);
        if (seen) begin
            model_run = 1;
            model_len = e.len;
        end else begin
            exp_load.delete();
        end
        tick();
    endtask

    task automatic fetch(input int pc);
        logic [7:0] e;
        PC = 8'(pc);
        e = (model_run && pc < model_len) ? model_mem[pc] : 8'h00;
        exp_inst.push_back(e);
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
    endtask

    task automatic do_reset();
        CLB = 1'b1;
        tick();
        CLB = 1'b0;
        model_run = 0;
        model_len = 0;
        img_q.delete();
        last_seen = 0;
        chk("rst_cpu_CLB", 32'(cpu_CLB), 32'h0);
        chk("rst_inst", 32'(INST), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_wr_ready", 32'(wr_ready), 32'h0);
        chk("rst_prog_len", 32'(prog_len), 32'h0);
        chk("rst_checksum", 32'(checksum), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
    endtask

    initial begin : timeout
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        // 1: idle after reset
        idle(3);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_cpu_CLB", 32'(cpu_CLB), 32'h0);
            chk("idle_inst", 32'(INST), 32'h0);
            chk("idle_wr_ready", 32'(wr_ready), 32'h0);
            chk("idle_busy", 32'(busy), 32'h0);
            chk("idle_prog_len", 32'(prog_len), 32'h0);
        end
        tick();

        // 2: basic load
        start_load();
        chk("load_busy", 32'(busy), 32'h1);
        chk("load_wr_ready", 32'(wr_ready), 32'h1);
        send(8'h1A, 0);
        send(8'h23, 0);
        send(8'h45, 1);
        chk("hold_cpu_CLB", 32'(cpu_CLB), 32'h0);
        chk("hold_wr_ready", 32'(wr_ready), 32'h0);
        expect_done();
        for (int p = 0; p < 4; p++) fetch(p);

        // 3: stall
        start_load();
        send(8'h11, 0);
        idle(2);
        send(8'h22, 1);
        expect_done();
        fetch(0);
        fetch(1);
        fetch(2);

        // 4: full image without wr_last
        start_load();
        for (int i = 0; i < 256; i++) send(8'(i), 0);
        chk("full_wr_ready", 32'(wr_ready), 32'h0);
        expect_done();
        chk("full_wr_ready_run", 32'(wr_ready), 32'h0);
        wr_valid = 1'b1;
        wr_data = 8'h99;
        idle(2);
        wr_valid = 1'b0;
        fetch(255);
        fetch(0);
        fetch(128);

        // 5: restart mid-load
        start_load();
        send(8'hAA, 0);
        send(8'hBB, 0);
        restart_with_byte(8'hCC);
        send(8'h55, 1);
        expect_done();
        fetch(0);
        fetch(1);

        // randomized loads over old memory contents
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 40);
            start_load();
            for (int i = 0; i < n; i++) begin
                idle($urandom_range(0, 2));
                send(8'($urandom), i == n - 1);
            end
            expect_done();
            for (int k = 0; k < 8; k++) fetch($urandom_range(0, 60));
        end

        // 6: reset in RUN, then in LOAD
        do_reset();
        fetch(0);
        start_load();
        send(8'h77, 0);
        send(8'h88, 0);
        do_reset();
        chk("rst_load_state_idle", 32'(busy), 32'h0);
        start_load();
        send(8'h3C, 0);
        send(8'hC3, 0);
        send(8'h0F, 1);
        expect_done();
        for (int p = 0; p < 4; p++) fetch(p);

        idle(3);
        chk("acc_queue_empty", 32'(exp_acc.size()), 32'h0);
        chk("load_queue_empty", 32'(exp_load.size()), 32'h0);
        chk("inst_queue_empty", 32'(exp_inst.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
